// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and constants for the counter sweep sequencer.
package counter_ctrl_pkg;

    localparam int unsigned DEF_W     = 32'd8;
    localparam int unsigned DEF_R     = 32'd4;
    localparam int unsigned DEF_DWELL = 32'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UP     = 3'd1,
        ST_DWELL  = 3'd2,
        ST_DOWN   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    // A zero dwell still needs a one-bit counter so the register exists.
    function automatic int unsigned dwell_cnt_w(input int unsigned dwell);
        dwell_cnt_w = (dwell < 32'd1) ? 32'd1 : $clog2(dwell + 32'd1);
    endfunction

endpackage

// File: rtl/counter_sweep_ctrl_if.sv
// Control/status bundle between the sweep sequencer and its controller.
// COUNTER_SWEEP_PAUSE_EN adds the PAUSE request line.
interface counter_sweep_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned R = DEF_R
);
    logic         START;
    logic         STOP;
    logic [W-1:0] LIMIT;
    logic [R-1:0] REPEATS;
`ifdef COUNTER_SWEEP_PAUSE_EN
    logic         PAUSE;
`endif
    logic [W-1:0] Y;
    logic         BUSY;
    logic         DIR_OUT;
    logic         DONE;

`ifdef COUNTER_SWEEP_PAUSE_EN
    modport master (output START, STOP, LIMIT, REPEATS, PAUSE,
                    input  Y, BUSY, DIR_OUT, DONE);
    modport slave  (input  START, STOP, LIMIT, REPEATS, PAUSE,
                    output Y, BUSY, DIR_OUT, DONE);
`else
    modport master (output START, STOP, LIMIT, REPEATS,
                    input  Y, BUSY, DIR_OUT, DONE);
    modport slave  (input  START, STOP, LIMIT, REPEATS,
                    output Y, BUSY, DIR_OUT, DONE);
`endif
endinterface

// File: rtl/counter_sweep_ctrl_counter.sv
// Up/down counter that saturates at both ends instead of wrapping.
module updown_bound_counter
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         CLK,
    input  logic         N_RESET,
    input  logic         EN,
    input  logic         DIR,
    input  logic         CLR,
    output logic [W-1:0] Y
);
    localparam logic [W-1:0] Y_MAX = {W{1'b1}};

    logic [W-1:0] r_y;

    // Count register: CLR wins, DIR=1 counts down, ends hold.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_y <= {W{1'b0}};
        end else if (CLR) begin
            r_y <= {W{1'b0}};
        end else if (EN && DIR && (r_y != {W{1'b0}})) begin
            r_y <= r_y - W'(1);
        end else if (EN && !DIR && (r_y != Y_MAX)) begin
            r_y <= r_y + W'(1);
        end else begin
            r_y <= r_y;
        end
    end

    assign Y = r_y;

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer driving a bounded up/down counter.
// COUNTER_SWEEP_PAUSE_EN enables the PAUSE freeze input.
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned R     = DEF_R,
    parameter int unsigned DWELL = DEF_DWELL
) (
    input  logic                 CLK,
    input  logic                 N_RESET,
    counter_sweep_ctrl_if.slave  bus
);
    localparam int unsigned      DW_W       = dwell_cnt_w(DWELL);
    localparam logic [DW_W-1:0]  DWELL_LAST = (DWELL > 32'd0) ? DW_W'(DWELL - 32'd1) : {DW_W{1'b0}};
    localparam logic [R-1:0]     SWEEP_MAX  = {R{1'b1}};

    state_e          r_state;
    logic [W-1:0]    r_lim;
    logic [R-1:0]    r_rep;
    logic [R-1:0]    r_sweep;
    logic [DW_W-1:0] r_dwell;
    logic            r_stop;
    logic            r_busy;
    logic            r_dir;
    logic            r_done;

    logic [W-1:0]    w_y;
    logic            w_en;
    logic            w_dir;
    logic            w_clr;
    logic            w_pause;
    logic            w_stop_seen;
    logic            w_at_top;
    logic            w_at_bottom;
    logic [R-1:0]    w_sweep_nx;
    logic            w_run_end;

`ifdef COUNTER_SWEEP_PAUSE_EN
    assign w_pause = bus.PAUSE;
`else
    assign w_pause = 1'b0;
`endif

    updown_bound_counter #(.W(W)) u_cnt (
        .CLK     (CLK),
        .N_RESET (N_RESET),
        .EN      (w_en),
        .DIR     (w_dir),
        .CLR     (w_clr),
        .Y       (w_y)
    );

    // Counter controls and end-of-ramp / end-of-run decisions.
    always_comb begin
        w_stop_seen = r_stop | bus.STOP;
        w_at_top    = ((w_y + W'(1)) == r_lim);
        w_at_bottom = (w_y <= W'(1));
        w_sweep_nx  = (r_sweep == SWEEP_MAX) ? r_sweep : (r_sweep + R'(1));
        w_run_end   = w_stop_seen | ((r_rep != {R{1'b0}}) & (w_sweep_nx == r_rep));
        w_en        = 1'b0;
        w_dir       = 1'b0;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: w_clr = bus.START & ~bus.STOP;
            // A STOP in UP turns the sweep around without taking the step.
            ST_UP:   w_en  = ~bus.STOP & ~w_pause;
            ST_DOWN: begin
                w_en  = ~w_pause;
                w_dir = 1'b1;
            end
            default: w_en = 1'b0;
        endcase
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge CLK or negedge N_RESET) begin
        if (!N_RESET) begin
            r_state <= ST_IDLE;
            r_lim   <= {W{1'b0}};
            r_rep   <= {R{1'b0}};
            r_sweep <= {R{1'b0}};
            r_dwell <= {DW_W{1'b0}};
            r_stop  <= 1'b0;
            r_busy  <= 1'b0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.START && !bus.STOP) begin
                        r_lim   <= bus.LIMIT;
                        r_rep   <= bus.REPEATS;
                        r_sweep <= {R{1'b0}};
                        r_stop  <= 1'b0;
                        if (bus.LIMIT == {W{1'b0}}) begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_UP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (bus.STOP) begin
                        r_state <= ST_DOWN;
                        r_dir   <= 1'b1;
                        r_stop  <= 1'b1;
                    end else if (!w_pause && w_at_top) begin
                        if (DWELL == 32'd0) begin
                            r_state <= ST_DOWN;
                            r_dir   <= 1'b1;
                        end else begin
                            r_state <= ST_DWELL;
                            r_dwell <= {DW_W{1'b0}};
                        end
                    end
                end
                ST_DWELL: begin
                    if (bus.STOP) begin
                        r_state <= ST_DOWN;
                        r_dir   <= 1'b1;
                        r_stop  <= 1'b1;
                    end else if (!w_pause) begin
                        if (r_dwell == DWELL_LAST) begin
                            r_state <= ST_DOWN;
                            r_dir   <= 1'b1;
                        end else begin
                            r_dwell <= r_dwell + DW_W'(1);
                        end
                    end
                end
                ST_DOWN: begin
                    if (bus.STOP) begin
                        r_stop <= 1'b1;
                    end
                    if (!w_pause && w_at_bottom) begin
                        r_sweep <= w_sweep_nx;
                        r_dir   <= 1'b0;
                        if (w_run_end) begin
                            r_state <= ST_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_UP;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_dir   <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y       = w_y;
    assign bus.BUSY    = r_busy;
    assign bus.DIR_OUT = r_dir;
    assign bus.DONE    = r_done;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Scoreboard bench: two sequencers (dwell 2 and dwell 0) share one stimulus;
// expected output trajectories are built from sweep rules and checked per cycle.
module tb_counter_sweep_ctrl;
    import counter_ctrl_pkg::*;

    localparam int W    = 8;
    localparam int R    = 4;
    localparam int DW_A = 2;
    localparam int DW_B = 0;

    localparam int S_IDLE  = 0;
    localparam int S_UP    = 1;
    localparam int S_DWELL = 2;
    localparam int S_DOWN  = 3;
    localparam int S_FIN   = 4;

    typedef struct { int y; int st; } ent_t;
    typedef struct { int cyc; int y; int st; } exp_t;

    logic         CLK = 1'b0;
    logic         N_RESET;
    logic         start;
    logic         stop;
    logic [W-1:0] limit;
    logic [R-1:0] repeats;
`ifdef COUNTER_SWEEP_PAUSE_EN
    logic         pause;
`endif

    counter_sweep_ctrl_if #(.W(W), .R(R)) bus_a ();
    counter_sweep_ctrl_if #(.W(W), .R(R)) bus_b ();

    assign bus_a.START   = start;
    assign bus_a.STOP    = stop;
    assign bus_a.LIMIT   = limit;
    assign bus_a.REPEATS = repeats;
    assign bus_b.START   = start;
    assign bus_b.STOP    = stop;
    assign bus_b.LIMIT   = limit;
    assign bus_b.REPEATS = repeats;
`ifdef COUNTER_SWEEP_PAUSE_EN
    assign bus_a.PAUSE   = pause;
    assign bus_b.PAUSE   = pause;
`endif

    counter_sweep_ctrl #(.W(W), .R(R), .DWELL(DW_A)) u_dut_a (
        .CLK(CLK), .N_RESET(N_RESET), .bus(bus_a));
    counter_sweep_ctrl #(.W(W), .R(R), .DWELL(DW_B)) u_dut_b (
        .CLK(CLK), .N_RESET(N_RESET), .bus(bus_b));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    ent_t scr[$];
    ent_t tr_a[$];
    ent_t tr_b[$];
    exp_t q_a[$];
    exp_t q_b[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input exp_t e, input logic [W-1:0] y,
                         input logic b, input logic d, input logic dn);
        logic [W-1:0] ey;
        logic eb, ed, edn;
        ey  = e.y[W-1:0];
        eb  = (e.st == S_UP) || (e.st == S_DWELL) || (e.st == S_DOWN);
        ed  = (e.st == S_DOWN);
        edn = (e.st == S_FIN);
        n_vec++;
        if (y !== ey || b !== eb || d !== ed || dn !== edn) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got Y=%0d BUSY=%0b DIR_OUT=%0b DONE=%0b, want Y=%0d BUSY=%0b DIR_OUT=%0b DONE=%0b",
                     nm, e.cyc, y, b, d, dn, ey, eb, ed, edn);
        end
    endtask

    // Monitor: whenever a cycle has an expected entry, compare the outputs.
    always @(negedge CLK) begin
        exp_t e;
        while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            e = q_a.pop_front();
            check("sweep_dwell2", e, bus_a.Y, bus_a.BUSY, bus_a.DIR_OUT, bus_a.DONE);
        end
        while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            check("sweep_dwell0", e, bus_b.Y, bus_b.BUSY, bus_b.DIR_OUT, bus_b.DONE);
        end
    end

    function automatic void push_e(input int y, input int st);
        ent_t e;
        e.y  = y;
        e.st = st;
        scr.push_back(e);
    endfunction

    // Nominal run: state during each cycle after the START edge.
    task automatic gen(input int lim, input int rep, input int dwell, input int nsw);
        int n;
        n = (rep == 0) ? nsw : rep;
        scr.delete();
        if (lim == 0) begin
            push_e(0, S_FIN);
        end else begin
            push_e(0, S_UP);
            for (int s = 1; s <= n; s++) begin
                for (int v = 1; v <= lim; v++)
                    push_e(v, (v == lim) ? ((dwell > 0) ? S_DWELL : S_DOWN) : S_UP);
                for (int d = 1; d <= dwell; d++)
                    push_e(lim, (d == dwell) ? S_DOWN : S_DWELL);
                for (int v = lim - 1; v >= 0; v--)
                    push_e(v, (v > 0) ? S_DOWN : ((s == n) ? S_FIN : S_UP));
            end
        end
    endtask

    function automatic int fin_idx();
        for (int i = 0; i < scr.size(); i++)
            if (scr[i].st == S_FIN) return i;
        return scr.size();
    endfunction

    // STOP sampled at edge index c: turn around (holding Y in UP/DWELL) and end at 0.
    task automatic apply_stop(input int c);
        ent_t e;
        int v;
        if (c < 1 || c > scr.size()) return;
        e = scr[c-1];
        if (e.st != S_UP && e.st != S_DWELL && e.st != S_DOWN) return;
        while (scr.size() > c) scr.delete(scr.size() - 1);
        if (e.st != S_DOWN) push_e(e.y, S_DOWN);
        v = e.y;
        do begin
            v = (v > 0) ? v - 1 : 0;
            push_e(v, (v > 0) ? S_DOWN : S_FIN);
        end while (v > 0);
    endtask

    // PAUSE high for edges c..c+p-1 freezes the run for p cycles.
    task automatic apply_pause(input int c, input int p);
        ent_t e;
        if (c < 1 || c > scr.size()) return;
        e = scr[c-1];
        if (e.st != S_UP && e.st != S_DWELL && e.st != S_DOWN) return;
        for (int k = 0; k < p; k++) scr.insert(c, e);
    endtask

    task automatic build(input int lim, input int rep, input int dwell, input int nsw,
                         input int sc, input int pc, input int pp);
        gen(lim, rep, dwell, nsw);
        if (sc > 0) apply_stop(sc);
        if (pp > 0) apply_pause(pc, pp);
    endtask

    task automatic mid_reset();
        exp_t z;
        N_RESET = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
`ifdef COUNTER_SWEEP_PAUSE_EN
        pause   = 1'b0;
`endif
        #1;
        z.cyc = cyc; z.y = 0; z.st = S_IDLE;
        check("async_reset_a", z, bus_a.Y, bus_a.BUSY, bus_a.DIR_OUT, bus_a.DONE);
        check("async_reset_b", z, bus_b.Y, bus_b.BUSY, bus_b.DIR_OUT, bus_b.DONE);
        q_a.delete();
        q_b.delete();
        repeat (2) @(posedge CLK);
        #2 N_RESET = 1'b1;
    endtask

    // Called at posedge+2 with both DUTs idle.
    task automatic run(input int lim, input int rep, input int nsw, input int sc,
                       input int pc, input int pp, input int rst_at);
        int len, base;
        bit both_run;
        build(lim, rep, DW_A, nsw, sc, pc, pp);
        tr_a = scr;
        build(lim, rep, DW_B, nsw, sc, pc, pp);
        tr_b = scr;
        len = ((tr_a.size() > tr_b.size()) ? tr_a.size() : tr_b.size()) + 2;
        while (tr_a.size() < len) tr_a.push_back('{0, S_IDLE});
        while (tr_b.size() < len) tr_b.push_back('{0, S_IDLE});
        base = cyc + 1;
        for (int i = 0; i < len; i++) begin
            q_a.push_back('{base + i, tr_a[i].y, tr_a[i].st});
            q_b.push_back('{base + i, tr_b[i].y, tr_b[i].st});
        end
        start   = 1'b1;
        stop    = 1'b0;
        limit   = W'(lim);
        repeats = R'(rep);
        for (int i = 1; i < len; i++) begin
            @(posedge CLK);
            #2;
            if (i - 1 == rst_at) begin
                mid_reset();
                return;
            end
            both_run = (tr_a[i-1].st != S_IDLE) && (tr_b[i-1].st != S_IDLE);
            start    = both_run && ($urandom_range(0, 5) == 0);
            stop     = (i == sc);
`ifdef COUNTER_SWEEP_PAUSE_EN
            pause    = (pp > 0) && (i >= pc) && (i < pc + pp);
`endif
            limit    = W'($urandom);
            repeats  = R'($urandom);
        end
        @(posedge CLK);
        #2;
        start = 1'b0;
        stop  = 1'b0;
`ifdef COUNTER_SWEEP_PAUSE_EN
        pause = 1'b0;
`endif
    endtask

    // Continuous mode needs a STOP no later than either DUT's nominal end.
    task automatic run_cont(input int lim, input int nsw, input bit rnd_stop);
        int fa, fb, c;
        gen(lim, 0, DW_A, nsw);
        fa = fin_idx();
        gen(lim, 0, DW_B, nsw);
        fb = fin_idx();
        c = (fa < fb) ? fa : fb;
        if (lim == 0) c = 0;
        else if (rnd_stop) c = $urandom_range(1, c);
        run(lim, 0, nsw, c, 0, 0, -1);
    endtask

    task automatic idle_start_stop();
        for (int i = 0; i < 3; i++) begin
            q_a.push_back('{cyc + 1 + i, 0, S_IDLE});
            q_b.push_back('{cyc + 1 + i, 0, S_IDLE});
        end
        start = 1'b1;
        stop  = 1'b1;
        limit = W'(4);
        repeats = R'(1);
        @(posedge CLK);
        #2;
        start = 1'b0;
        stop  = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
    endtask

    initial begin
        exp_t z;
        int lim, rep, sc, pc, pp;
        N_RESET = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        limit   = {W{1'b0}};
        repeats = {R{1'b0}};
`ifdef COUNTER_SWEEP_PAUSE_EN
        pause   = 1'b0;
`endif
        #1 N_RESET = 1'b0;
        #2;
        z.cyc = 0; z.y = 0; z.st = S_IDLE;
        check("reset_a", z, bus_a.Y, bus_a.BUSY, bus_a.DIR_OUT, bus_a.DONE);
        check("reset_b", z, bus_b.Y, bus_b.BUSY, bus_b.DIR_OUT, bus_b.DONE);
        repeat (2) @(posedge CLK);
        #2 N_RESET = 1'b1;

        run(3, 1, 1, 0, 0, 0, -1);          // basic sweep with dwell
        run(2, 2, 1, 0, 0, 0, -1);          // two sweeps
        run(5, 0, 1, 4, 0, 0, -1);          // STOP at Y=3 in UP
        run(0, 3, 1, 0, 0, 0, -1);          // LIMIT=0
        idle_start_stop();                  // STOP beats START in IDLE
        run(3, 1, 1, 0, 0, 0, 4);           // reset mid-dwell
        run(4, 2, 1, 0, 0, 0, -1);          // normal run after reset
`ifdef COUNTER_SWEEP_PAUSE_EN
        run(6, 1, 1, 0, 3, 4, -1);          // PAUSE at Y=2 for 4 cycles
`endif
        run_cont(1, 40, 1'b0);              // many continuous sweeps
        run(255, 1, 1, 0, 0, 0, -1);        // full-range LIMIT
        run(1, 15, 1, 0, 0, 0, -1);         // maximum REPEATS

        for (int it = 0; it < 40; it++) begin
            lim = $urandom_range(0, 10);
            rep = $urandom_range(0, 3);
            if (rep == 0) begin
                run_cont(lim, $urandom_range(1, 3), 1'b1);
            end else begin
                sc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 * lim + 4) : 0;
                pc = 0;
                pp = 0;
`ifdef COUNTER_SWEEP_PAUSE_EN
                if (sc == 0 && $urandom_range(0, 1) == 1) begin
                    pc = $urandom_range(1, 2 * lim + 2);
                    pp = $urandom_range(1, 3);
                end
`endif
                run(lim, rep, 1, sc, pc, pp, -1);
            end
        end

        repeat (3) @(posedge CLK);
        #2;
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d/%0d entries left, want 0/0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer that owns a bounded up/down counter and drives it through programmed triangle sweeps: ramp 0→LIMIT, dwell, ramp LIMIT→0, repeated REPEATS times.
- Sits between control logic (START/STOP pulses) and the counter datapath.
- Reports busy, direction and one-cycle completion.
- The counter never wraps.

Parameters:
- W, 8: counter/LIMIT width.
- R, 4: REPEATS width.
- DWELL, 2: extra cycles Y holds LIMIT at the top; 0 = no dwell state.

Ports:
- CLK  in  1  clock, all state on posedge.
- N_RESET  in  1  asynchronous active-low reset.
- START  in  1  level sampled each edge; begins a run from IDLE.
- STOP  in  1  level sampled each edge; graceful ramp-down request.
- LIMIT  in  W  sweep top; latched on accepted START.
- REPEATS  in  R  sweep count; latched on accepted START; 0 = continuous until STOP.
- Y  out  W  counter value.
- BUSY  out  1  high in UP/DWELL/DOWN.
- DIR_OUT  out  1  1 while in DOWN, else 0.
- DONE  out  1  one-cycle pulse at run end.

Behaviour:
- Reset (async, N_RESET=0): state IDLE; Y=0, BUSY=0, DIR_OUT=0, DONE=0; latched LIMIT/REPEATS, sweep counter and dwell counter = 0.
- Outputs are registered. A state acts on the edge after entry; Y does not change on the entry edge, except in UP/DOWN where the final step and the transition share an edge.
- IDLE:
  - START=1 and STOP=0: latch LIMIT/REPEATS; clear sweep counter.
  - If LIMIT=0: go to FINISH.
  - Otherwise: go to UP.
  - STOP has priority over START in IDLE, so a simultaneous START is ignored.
- UP:
  - Each edge: Y<=Y+1.
  - On the edge where Y becomes LIMIT: go to DWELL, or to DOWN if DWELL=0.
- DWELL: Y held; stays exactly DWELL cycles, then goes to DOWN. Y=LIMIT is visible for DWELL+1 cycles in total.
- DOWN:
  - Each edge: Y<=Y-1 if Y>0.
  - On the edge where Y reaches 0 (Y≤1): increment the sweep counter.
  - If STOP was seen, or REPEATS≠0 and the sweep count equals REPEATS: go to FINISH.
  - Otherwise: go to UP, with Y=0 visible for one cycle.
- FINISH: DONE=1 and BUSY=0 this cycle; next edge DONE=0 and state IDLE.
- STOP while in UP/DWELL: next state DOWN; Y unchanged on that edge; a sticky stop flag is set. Run ends at the next Y=0.
- STOP in UP with Y=0: enter DOWN, then FINISH on the following edge.
- STOP in DOWN: sets the stop flag only.
- STOP in FINISH/IDLE: no effect.
- START while BUSY: ignored. LIMIT/REPEATS changes mid-run: ignored.
- Sweep counter saturates at its maximum in continuous mode.
- Reset mid-run: immediate return to IDLE/zero outputs; no DONE.
- Arithmetic: W-bit unsigned. Y is bounded to [0, LIMIT] by construction.

Optional Feature:
- Macro: COUNTER_SWEEP_PAUSE_EN.
- Defined: adds input PAUSE (1 bit). PAUSE=1 in UP/DWELL/DOWN freezes Y, state, dwell counter and sweep counter; BUSY stays 1. STOP overrides PAUSE (transition to DOWN still happens, but Y holds until PAUSE=0). PAUSE is ignored in IDLE/FINISH.
- Undefined: no PAUSE port; behaves as PAUSE=0.

Decomposition:
- Package counter_ctrl_pkg holds:
  - state enum typedef (IDLE, UP, DWELL, DOWN, FINISH);
  - default width constants;
  - dwell-counter width function ($clog2(DWELL+1)).
- One sub-module, updown_bound_counter (inputs CLK, N_RESET, EN, DIR, CLR; output Y; no wrap). The FSM drives its EN and DIR.

Test Plan:
1. LIMIT=3, REPEATS=1, DWELL=2; START pulse at edge k → Y after edges k..k+8 = 0,1,2,3,3,3,2,1,0. DONE=1 for the single cycle after k+8; BUSY low from then on.
2. LIMIT=2, REPEATS=2, DWELL=0 → Y = 0,1,2,1,0,1,2,1,0 then DONE. DIR_OUT is 1 exactly during the DOWN cycles.
3. LIMIT=5, REPEATS=0; STOP pulse while Y=3 in UP → Y holds 3 for one cycle, then 2,1,0, then DONE. There is no further sweep.
4. LIMIT=0 with START → FINISH next cycle; DONE pulse; Y stays 0; BUSY never high.
5. N_RESET low asynchronously mid-DWELL → Y=0, BUSY=0, DONE=0 immediately (before the next edge). A START after release runs normally.
6. (COUNTER_SWEEP_PAUSE_EN) PAUSE=1 for 4 cycles during UP at Y=2 → Y stays 2 for 4 cycles, then resumes at 3. Total run length grows by 4 cycles.
